// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - shared CSR addresses, cause codes and FSM encoding for the trap sequencer
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [4:0] CAUSE_INST_ADDR = 5'd0;
    localparam logic [4:0] CAUSE_ILLEGAL   = 5'd2;
    localparam logic [4:0] CAUSE_BREAK     = 5'd3;
    localparam logic [4:0] CAUSE_LD_ADDR   = 5'd4;
    localparam logic [4:0] CAUSE_ST_ADDR   = 5'd6;
    localparam logic [4:0] CAUSE_IRQ_TIMER = 5'd7;
    localparam logic [4:0] CAUSE_ECALL     = 5'd11;
    localparam logic [4:0] CAUSE_IRQ_EXT   = 5'd11;
    localparam logic       CAUSE_IRQ_FLAG  = 1'b1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_DRAIN    = 3'd1;
    localparam logic [2:0] ST_W_EPC    = 3'd2;
    localparam logic [2:0] ST_W_CAUSE  = 3'd3;
    localparam logic [2:0] ST_W_TVAL   = 3'd4;
    localparam logic [2:0] ST_W_STATUS = 3'd5;
    localparam logic [2:0] ST_REDIRECT = 3'd6;

    typedef struct packed {
        logic illegal;
        logic inst_addr;
        logic ld_addr;
        logic st_addr;
        logic ecall;
        logic ebreak;
        logic mret;
    } trap_events_t;

    // Low 13 bits of mstatus as written by the sequencer: MPP = M, MPIE at bit 7, MIE at bit 3.
    function automatic logic [12:0] mstatus_bits(input logic mpie_val, input logic mie_val);
        return {2'b11, 3'b000, mpie_val, 3'b000, mie_val, 3'b000};
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - combinational priority encoder for exceptions, mret and gated interrupts
module trap_prio_enc
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  trap_events_t      ev,
    input  logic              irq_ext,
    input  logic              irq_timer,
    output logic              take,
    output logic              is_mret,
    output logic              tval_sel,
    output logic [XLEN-1:0]   cause
);

    logic       irq;
    logic [4:0] code;

    always_comb begin
        take     = 1'b0;
        is_mret  = 1'b0;
        tval_sel = 1'b0;
        irq      = 1'b0;
        code     = 5'd0;
        if (ev.ebreak) begin
            take = 1'b1;
            code = CAUSE_BREAK;
        end else if (ev.inst_addr) begin
            take     = 1'b1;
            code     = CAUSE_INST_ADDR;
            tval_sel = 1'b1;
        end else if (ev.illegal) begin
            take = 1'b1;
            code = CAUSE_ILLEGAL;
        end else if (ev.ecall) begin
            take = 1'b1;
            code = CAUSE_ECALL;
        end else if (ev.ld_addr) begin
            take     = 1'b1;
            code     = CAUSE_LD_ADDR;
            tval_sel = 1'b1;
        end else if (ev.st_addr) begin
            take     = 1'b1;
            code     = CAUSE_ST_ADDR;
            tval_sel = 1'b1;
        end else if (ev.mret) begin
            take    = 1'b1;
            is_mret = 1'b1;
        end else if (irq_ext) begin
            take = 1'b1;
            irq  = CAUSE_IRQ_FLAG;
            code = CAUSE_IRQ_EXT;
        end else if (irq_timer) begin
            take = 1'b1;
            irq  = CAUSE_IRQ_FLAG;
            code = CAUSE_IRQ_TIMER;
        end
    end

    assign cause = {irq, {(XLEN-6){1'b0}}, code};

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap sequencer driving the CSR write port and fetch redirect
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ex_illegal,
    input  logic            i_ex_inst_addr,
    input  logic            i_ex_ld_addr,
    input  logic            i_ex_st_addr,
    input  logic            i_ecall,
    input  logic            i_ebreak,
    input  logic            i_mret,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_badaddr,
    input  logic            i_irq_timer,
    input  logic            i_irq_ext,
    input  logic            i_mstatus_mie,
    input  logic            i_mstatus_mpie,
    input  logic            i_mie_mtie,
    input  logic            i_mie_meie,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_drained,
    output logic            o_stall,
    output logic            o_flush,
    output logic            o_csr_we,
    output logic [11:0]     o_csr_addr,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_busy
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    trap_events_t    ev;
    logic            take;
    logic            is_mret;
    logic            tval_sel;
    logic [XLEN-1:0] cause;

    logic [2:0]      state;
    logic [2:0]      state_nx;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] tval_q;
    logic            mret_q;
    logic            first_q;
    logic            accept;

    assign ev = '{illegal:   i_ex_illegal,
                  inst_addr: i_ex_inst_addr,
                  ld_addr:   i_ex_ld_addr,
                  st_addr:   i_ex_st_addr,
                  ecall:     i_ecall,
                  ebreak:    i_ebreak,
                  mret:      i_mret};

    trap_prio_enc #(.XLEN(XLEN)) u_prio (
        .ev        (ev),
        .irq_ext   (i_irq_ext & i_mie_meie & i_mstatus_mie),
        .irq_timer (i_irq_timer & i_mie_mtie & i_mstatus_mie),
        .take      (take),
        .is_mret   (is_mret),
        .tval_sel  (tval_sel),
        .cause     (cause)
    );

    assign accept = (state == ST_IDLE) && take;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            tval_q  <= '0;
            mret_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state   <= state_nx;
            first_q <= accept;
            if (accept) begin
                epc_q   <= i_pc;
                cause_q <= cause;
                tval_q  <= tval_sel ? i_badaddr : '0;
                mret_q  <= is_mret;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (take) state_nx = ST_DRAIN;
            ST_DRAIN:    if (i_drained) state_nx = mret_q ? ST_W_STATUS : ST_W_EPC;
            ST_W_EPC:    state_nx = ST_W_CAUSE;
            ST_W_CAUSE:  state_nx = ST_W_TVAL;
            ST_W_TVAL:   state_nx = ST_W_STATUS;
            ST_W_STATUS: state_nx = ST_REDIRECT;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // Status and redirect values come from live CSR inputs, not from the accept-time snapshot.
    always_comb begin
        o_flush       = 1'b0;
        o_csr_we      = 1'b0;
        o_csr_addr    = 12'h000;
        o_csr_wdata   = '0;
        o_redirect    = 1'b0;
        o_redirect_pc = '0;
        case (state)
            ST_DRAIN: o_flush = first_q;
            ST_W_EPC: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MEPC;
                o_csr_wdata = epc_q & ALIGN_MASK;
            end
            ST_W_CAUSE: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MCAUSE;
                o_csr_wdata = cause_q;
            end
            ST_W_TVAL: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MTVAL;
                o_csr_wdata = tval_q;
            end
            ST_W_STATUS: begin
                o_csr_we    = 1'b1;
                o_csr_addr  = CSR_MSTATUS;
                o_csr_wdata = mret_q ? XLEN'(mstatus_bits(1'b1, i_mstatus_mpie))
                                     : XLEN'(mstatus_bits(i_mstatus_mie, 1'b0));
            end
            ST_REDIRECT: begin
                o_redirect    = 1'b1;
                o_redirect_pc = (mret_q ? i_mepc : i_mtvec) & ALIGN_MASK;
            end
            default: ;
        endcase
    end

    assign o_busy  = (state != ST_IDLE);
    assign o_stall = o_busy;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl with a step-list reference model
module tb_trap_ctrl;

    localparam int XLEN = 32;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_ex_illegal, i_ex_inst_addr, i_ex_ld_addr, i_ex_st_addr;
    logic            i_ecall, i_ebreak, i_mret;
    logic [XLEN-1:0] i_pc, i_badaddr, i_mtvec, i_mepc;
    logic            i_irq_timer, i_irq_ext;
    logic            i_mstatus_mie, i_mstatus_mpie, i_mie_mtie, i_mie_meie;
    logic            i_drained;
    logic            o_stall, o_flush, o_csr_we, o_redirect, o_busy;
    logic [11:0]     o_csr_addr;
    logic [XLEN-1:0] o_csr_wdata, o_redirect_pc;

    trap_ctrl #(.XLEN(XLEN)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_ex_illegal(i_ex_illegal), .i_ex_inst_addr(i_ex_inst_addr),
        .i_ex_ld_addr(i_ex_ld_addr), .i_ex_st_addr(i_ex_st_addr),
        .i_ecall(i_ecall), .i_ebreak(i_ebreak), .i_mret(i_mret),
        .i_pc(i_pc), .i_badaddr(i_badaddr),
        .i_irq_timer(i_irq_timer), .i_irq_ext(i_irq_ext),
        .i_mstatus_mie(i_mstatus_mie), .i_mstatus_mpie(i_mstatus_mpie),
        .i_mie_mtie(i_mie_mtie), .i_mie_meie(i_mie_meie),
        .i_mtvec(i_mtvec), .i_mepc(i_mepc), .i_drained(i_drained),
        .o_stall(o_stall), .o_flush(o_flush), .o_csr_we(o_csr_we),
        .o_csr_addr(o_csr_addr), .o_csr_wdata(o_csr_wdata),
        .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: pending list of steps 0=epc 1=cause 2=tval 3=status 4=redirect
    bit              m_busy = 0, m_drain = 0, m_first = 0, m_mret = 0;
    int              m_steps[$];
    logic [31:0]     m_epc, m_cause, m_tval;

    function automatic void m_select(output bit hit, output bit is_mret,
                                     output logic [31:0] cause, output bit tval_used);
        bit ev[6];
        int codes[6];
        bit mis[6];
        ev    = '{i_ebreak, i_ex_inst_addr, i_ex_illegal, i_ecall, i_ex_ld_addr, i_ex_st_addr};
        codes = '{3, 0, 2, 11, 4, 6};
        mis   = '{0, 1, 0, 0, 1, 1};
        hit = 0; is_mret = 0; cause = 0; tval_used = 0;
        for (int i = 0; i < 6; i++) begin
            if (ev[i] && !hit) begin
                hit = 1; cause = codes[i]; tval_used = mis[i];
            end
        end
        if (!hit && i_mret) begin
            hit = 1; is_mret = 1;
        end else if (!hit && i_irq_ext && i_mie_meie && i_mstatus_mie) begin
            hit = 1; cause = 32'h8000_000B;
        end else if (!hit && i_irq_timer && i_mie_mtie && i_mstatus_mie) begin
            hit = 1; cause = 32'h8000_0007;
        end
    endfunction

    always @(posedge i_clk) begin
        bit hit, im, tu;
        logic [31:0] c;
        cyc = cyc + 1;
        if (i_rst) begin
            m_busy = 0; m_drain = 0; m_first = 0; m_steps.delete();
        end else if (!m_busy) begin
            m_select(hit, im, c, tu);
            if (hit) begin
                m_epc = i_pc; m_cause = c; m_tval = tu ? i_badaddr : 32'h0; m_mret = im;
                m_busy = 1; m_drain = 1; m_first = 1;
                if (im) m_steps = '{3, 4};
                else    m_steps = '{0, 1, 2, 3, 4};
            end
        end else if (m_drain) begin
            m_first = 0;
            if (i_drained) m_drain = 0;
        end else begin
            void'(m_steps.pop_front());
            if (m_steps.size() == 0) m_busy = 0;
        end
    end

    int          n_wr = 0, n_rd = 0;
    bit          busy_seen = 0;
    int          wr_cyc[16], rd_cyc[4];
    logic [11:0] wr_addr[16];
    logic [31:0] wr_data[16], rd_pc[4];

    always @(negedge i_clk) begin
        logic e_stall, e_flush, e_we, e_rd;
        logic [11:0] e_addr;
        logic [31:0] e_data, e_pc;
        e_stall = 0; e_flush = 0; e_we = 0; e_rd = 0; e_addr = 0; e_data = 0; e_pc = 0;
        if (m_busy) begin
            e_stall = 1;
            if (m_drain) e_flush = m_first;
            else begin
                case (m_steps[0])
                    0: begin e_we = 1; e_addr = 12'h341; e_data = m_epc & ~32'h3; end
                    1: begin e_we = 1; e_addr = 12'h342; e_data = m_cause; end
                    2: begin e_we = 1; e_addr = 12'h343; e_data = m_tval; end
                    3: begin
                        e_we = 1; e_addr = 12'h300;
                        e_data = m_mret ? (32'h1880 | (i_mstatus_mpie ? 32'h8 : 32'h0))
                                        : (32'h1800 | (i_mstatus_mie ? 32'h80 : 32'h0));
                    end
                    default: begin e_rd = 1; e_pc = (m_mret ? i_mepc : i_mtvec) & ~32'h3; end
                endcase
            end
        end
        chk("stall", o_stall, e_stall);
        chk("busy", o_busy, e_stall);
        chk("flush", o_flush, e_flush);
        chk("csr_we", o_csr_we, e_we);
        chk("csr_addr", o_csr_addr, e_addr);
        chk("csr_wdata", o_csr_wdata, e_data);
        chk("redirect", o_redirect, e_rd);
        chk("redirect_pc", o_redirect_pc, e_pc);
        if (o_csr_we && n_wr < 16) begin
            wr_cyc[n_wr] = cyc; wr_addr[n_wr] = o_csr_addr; wr_data[n_wr] = o_csr_wdata; n_wr++;
        end
        if (o_redirect && n_rd < 4) begin
            rd_cyc[n_rd] = cyc; rd_pc[n_rd] = o_redirect_pc; n_rd++;
        end
        if (o_busy) busy_seen = 1;
    end

    task automatic clear_log();
        n_wr = 0; n_rd = 0; busy_seen = 0;
    endtask

    // ev bits: illegal, inst_addr, ld_addr, st_addr, ecall, ebreak, mret
    task automatic set_ev(input logic [6:0] e);
        {i_ex_illegal, i_ex_inst_addr, i_ex_ld_addr, i_ex_st_addr, i_ecall, i_ebreak, i_mret} = e;
    endtask

    task automatic pulse(input logic [6:0] e, output int t);
        @(posedge i_clk); #1;
        set_ev(e);
        t = cyc;
        @(posedge i_clk); #1;
        set_ev(7'b0);
    endtask

    initial begin
        int t;
        i_rst = 1; set_ev(7'b0);
        i_pc = 32'h100; i_badaddr = 0; i_mtvec = 32'h203; i_mepc = 0;
        i_irq_timer = 0; i_irq_ext = 0;
        i_mstatus_mie = 1; i_mstatus_mpie = 0; i_mie_mtie = 1; i_mie_meie = 1;
        i_drained = 1;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 0;
        @(negedge i_clk);
        chk("reset_busy", o_busy, 0);
        chk("reset_wdata", o_csr_wdata, 0);

        clear_log();
        pulse(7'b1000000, t);
        repeat (8) @(posedge i_clk);
        @(negedge i_clk);
        chk("ill_nwr", n_wr, 4);
        chk("ill_epc", {wr_addr[0], wr_data[0]}, {12'h341, 32'h100});
        chk("ill_cause", {wr_addr[1], wr_data[1]}, {12'h342, 32'h2});
        chk("ill_tval", {wr_addr[2], wr_data[2]}, {12'h343, 32'h0});
        chk("ill_status", {wr_addr[3], wr_data[3]}, {12'h300, 32'h1880});
        chk("ill_epc_cyc", wr_cyc[0], t + 2);
        chk("ill_status_cyc", wr_cyc[3], t + 5);
        chk("ill_redir", rd_pc[0], 32'h200);
        chk("ill_redir_cyc", rd_cyc[0], t + 6);

        clear_log();
        i_badaddr = 32'h13;
        pulse(7'b0010011, t);
        repeat (8) @(posedge i_clk);
        @(negedge i_clk);
        chk("sim_nwr", n_wr, 4);
        chk("sim_path", wr_addr[0], 12'h341);
        chk("sim_cause", wr_data[1], 32'h3);
        chk("sim_tval", wr_data[2], 32'h0);

        clear_log();
        i_badaddr = 32'h1001;
        i_drained = 0;
        pulse(7'b0010000, t);
        repeat (3) @(posedge i_clk);
        #1 i_drained = 1;
        repeat (8) @(posedge i_clk);
        @(negedge i_clk);
        chk("slow_cause", wr_data[1], 32'h4);
        chk("slow_tval", {wr_addr[2], wr_data[2]}, {12'h343, 32'h1001});
        chk("slow_tval_cyc", wr_cyc[2], t + 7);
        chk("slow_redir_cyc", rd_cyc[0], t + 9);

        clear_log();
        i_mepc = 32'h406; i_mstatus_mpie = 1;
        pulse(7'b0000001, t);
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        chk("mret_nwr", n_wr, 1);
        chk("mret_status", {wr_addr[0], wr_data[0]}, {12'h300, 32'h1888});
        chk("mret_status_cyc", wr_cyc[0], t + 2);
        chk("mret_redir", rd_pc[0], 32'h404);
        chk("mret_redir_cyc", rd_cyc[0], t + 3);

        clear_log();
        @(posedge i_clk); #1;
        i_irq_timer = 1; i_irq_ext = 1;
        t = cyc;
        @(posedge i_clk); #1;
        i_irq_timer = 0; i_irq_ext = 0;
        repeat (8) @(posedge i_clk);
        @(negedge i_clk);
        chk("irq_nwr", n_wr, 4);
        chk("irq_cause", wr_data[1], 32'h8000_000B);
        chk("irq_epc_cyc", wr_cyc[0], t + 2);

        clear_log();
        @(posedge i_clk); #1;
        i_mstatus_mie = 0; i_irq_timer = 1; i_irq_ext = 1;
        repeat (6) @(posedge i_clk);
        #1 i_irq_timer = 0; i_irq_ext = 0; i_mstatus_mie = 1;
        @(negedge i_clk);
        chk("irq_off_busy", busy_seen, 0);
        chk("irq_off_nwr", n_wr, 0);

        clear_log();
        pulse(7'b1000000, t);
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_rst = 1;
        @(posedge i_clk); #1;
        i_rst = 0;
        @(negedge i_clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_we", o_csr_we, 0);
        repeat (6) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_nwr", n_wr, 2);
        chk("rst_nrd", n_rd, 0);

        clear_log();
        pulse(7'b0000100, t);
        repeat (6) @(posedge i_clk);
        #1 set_ev(7'b0001000); i_badaddr = 32'h2002; i_pc = 32'h300;
        @(posedge i_clk); #1 set_ev(7'b0);
        repeat (9) @(posedge i_clk);
        @(negedge i_clk);
        chk("b2b_nwr", n_wr, 8);
        chk("b2b_cause1", wr_data[1], 32'hB);
        chk("b2b_epc2", wr_data[4], 32'h300);
        chk("b2b_epc2_cyc", wr_cyc[4], t + 9);
        chk("b2b_cause2", wr_data[5], 32'h6);
        chk("b2b_tval2", wr_data[6], 32'h2002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
